// File: rtl/glyph_blitter.sv
// Glyph ROM to framebuffer blitter: streams a 16x16 glyph out of the ROM and writes
// the on-screen, non-keyed pixels into the framebuffer write port.
module glyph_blitter #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned FB_AW       = 19,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
    parameter bit          TRANSP_EN   = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [7:0]       req_glyph_i,
    input  logic [9:0]       req_x_i,
    input  logic [9:0]       req_y_i,
    output logic [16:0]      glyph_addr_o,
    input  logic [23:0]      glyph_pixel_i,
    output logic             fb_we_o,
    output logic [FB_AW-1:0] fb_addr_o,
    output logic [23:0]      fb_data_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain1, StDrain2} state_e;

    state_e             state_q, state_d;
    logic [16:0]        addr_q, addr_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic               pv_q, pv_d;
    logic [10:0]        sx_q, sx_d, sy_q, sy_d;
    logic               we_q, we_d;
    logic [FB_AW-1:0]   fa_q, fa_d;
    logic [23:0]        fd_q, fd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pix_keyed;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StFetch;
                    addr_d  = {1'b0, req_glyph_i, 8'h00};
                    x_d     = req_x_i;
                    y_d     = req_y_i;
                end
            end
            StFetch: begin
                // Low byte is {row, col}; incrementing it gives the row-major walk.
                if (addr_q[7:0] == 8'hFF) begin
                    state_d = StDrain1;
                end else begin
                    addr_d = addr_q + 17'd1;
                end
            end
            StDrain1: state_d = StDrain2;
            StDrain2: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Screen coordinates travel with the ROM read so they line up with glyph_pixel_i.
    always_comb begin
        pv_d      = (state_q == StFetch);
        sx_d      = {1'b0, x_q} + {7'b0, addr_q[3:0]};
        sy_d      = {1'b0, y_q} + {7'b0, addr_q[7:4]};
        pix_keyed = TRANSP_EN && (glyph_pixel_i == TRANSPARENT);
        we_d      = pv_q && (32'(sx_q) < SCREEN_W) && (32'(sy_q) < SCREEN_H) && !pix_keyed;
        fa_d      = we_d ? FB_AW'(32'(sy_q) * SCREEN_W + 32'(sx_q)) : fa_q;
        fd_d      = we_d ? glyph_pixel_i : fd_q;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDrain2);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pv_q    <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            we_q    <= 1'b0;
            fa_q    <= '0;
            fd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pv_q    <= pv_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            we_q    <= we_d;
            fa_q    <= fa_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign glyph_addr_o = addr_q;
    assign fb_we_o      = we_q;
    assign fb_addr_o    = fa_q;
    assign fb_data_o    = fd_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_glyph_blitter.sv
// Randomized bench for glyph_blitter: a cycle-indexed model derived from the request
// time checks every output each cycle; literal checks pin the model on known glyphs.
module tb_glyph_blitter;

    localparam logic [23:0] TR = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_glyph = '0;
    logic [9:0]  req_x = '0;
    logic [9:0]  req_y = '0;

    logic        req_ready, fb_we, busy, done;
    logic [16:0] glyph_addr;
    logic [23:0] glyph_pixel, fb_data;
    logic [18:0] fb_addr;
    logic        ready2, we2, busy2, done2;
    logic [16:0] gaddr2;
    logic [23:0] gpix2, fd2;
    logic [18:0] fa2;

    logic [23:0] rom [0:131071];

    glyph_blitter u_dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_glyph_i(req_glyph), .req_x_i(req_x), .req_y_i(req_y),
        .glyph_addr_o(glyph_addr), .glyph_pixel_i(glyph_pixel), .fb_we_o(fb_we),
        .fb_addr_o(fb_addr), .fb_data_o(fb_data), .busy_o(busy), .done_o(done)
    );

    glyph_blitter #(.TRANSP_EN(1'b0)) u_dut_nokey (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(ready2),
        .req_glyph_i(req_glyph), .req_x_i(req_x), .req_y_i(req_y),
        .glyph_addr_o(gaddr2), .glyph_pixel_i(gpix2), .fb_we_o(we2),
        .fb_addr_o(fa2), .fb_data_o(fd2), .busy_o(busy2), .done_o(done2)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        glyph_pixel <= rom[glyph_addr];
        gpix2       <= rom[gaddr2];
    end

    int passed = 0;
    int total  = 0;

    // Model state and per-cycle expectations
    int          cyc = 0;
    bit          m_live = 0, m_active = 0, m_ready = 1;
    int          m_t, m_x, m_y;
    logic [7:0]  m_g;
    logic        e_busy, e_done, e_we, e_we2;
    logic [16:0] e_gaddr;
    logic [18:0] e_fa, e_fa2;
    logic [23:0] e_fd, e_fd2;

    // Observations
    logic [18:0] wq_a[$];
    logic [23:0] wq_d[$];
    int          acc_q[$];
    int          n_wr2 = 0, n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    task automatic draw(input logic [7:0] g, input logic [9:0] x, input logic [9:0] y);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_glyph = g; req_x = x; req_y = y;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 600);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_glyph = 8'($urandom); req_x = 10'($urandom); req_y = 10'($urandom);
        n = 0;
        while (!done && n < 600) begin @(negedge clk); n++; end
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int s, d, s2, a, mx, wait_n;
        for (int i = 0; i < 131072; i++) begin
            logic [31:0] v;
            v = $urandom;
            rom[i] = (v[1:0] == 2'b00) ? TR : v[31:8];
        end
        for (int i = 0; i < 256; i++) begin
            rom[256 + i] = 24'h000100 + 24'(i);
            rom[512 + i] = (((i >> 4) + (i & 15)) % 2 == 1) ? TR : 24'h123456;
        end

        fork
            forever begin  // reference model
                @(posedge clk);
                if (reset) begin
                    m_live = 1; m_active = 0; m_ready = 1;
                    e_busy = 0; e_done = 0; e_gaddr = '0;
                    e_we = 0; e_fa = '0; e_fd = '0; e_we2 = 0; e_fa2 = '0; e_fd2 = '0;
                end else if (m_live) begin
                    int k, idx, sx, sy;
                    logic [23:0] pix;
                    if (m_ready && req_valid) begin
                        m_active = 1; m_t = cyc; m_g = req_glyph; m_x = req_x; m_y = req_y;
                    end
                    e_busy = 0; e_done = 0; e_we = 0; e_we2 = 0;
                    if (m_active) begin
                        k = cyc + 1 - m_t;
                        e_busy = (k >= 1 && k <= 258);
                        e_done = (k == 258);
                        if (k >= 1 && k <= 256) e_gaddr = {1'b0, m_g, 8'(k - 1)};
                        if (k >= 3 && k <= 258) begin
                            idx = k - 3;
                            sx  = m_x + idx % 16;
                            sy  = m_y + idx / 16;
                            pix = rom[{1'b0, m_g, 8'(idx)}];
                            if (sx < 640 && sy < 480) begin
                                e_we2 = 1; e_fa2 = 19'(sy * 640 + sx); e_fd2 = pix;
                                if (pix != TR) begin
                                    e_we = 1; e_fa = 19'(sy * 640 + sx); e_fd = pix;
                                end
                            end
                        end
                        if (k >= 259) m_active = 0;
                    end
                    m_ready = !m_active;
                end
                cyc++;
            end
            forever begin  // per-cycle compare and monitor
                @(negedge clk);
                if (m_live) begin
                    chk("req_ready", 32'(req_ready), 32'(m_ready));
                    chk("busy", 32'(busy), 32'(e_busy));
                    chk("done", 32'(done), 32'(e_done));
                    chk("glyph_addr", 32'(glyph_addr), 32'(e_gaddr));
                    chk("fb_we", 32'(fb_we), 32'(e_we));
                    chk("fb_addr", 32'(fb_addr), 32'(e_fa));
                    chk("fb_data", 32'(fb_data), 32'(e_fd));
                    chk("nokey_fb_we", 32'(we2), 32'(e_we2));
                    chk("nokey_fb_addr", 32'(fa2), 32'(e_fa2));
                    chk("nokey_fb_data", 32'(fd2), 32'(e_fd2));
                    if (fb_we) begin wq_a.push_back(fb_addr); wq_d.push_back(fb_data); end
                    if (we2) n_wr2++;
                    if (done) n_done++;
                    if (req_valid && req_ready && !reset) acc_q.push_back(cyc);
                end
            end
        join_none

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_gaddr", 32'(glyph_addr), 32'd0);
        s = wq_a.size();
        repeat (20) @(negedge clk);
        chk("idle_writes", 32'(wq_a.size() - s), 32'd0);

        // Basic draw
        s = wq_a.size(); d = n_done;
        draw(8'd1, 10'd100, 10'd50);
        chk("basic_count", 32'(wq_a.size() - s), 32'd256);
        if (wq_a.size() - s == 256) begin
            chk("basic_first_addr", 32'(wq_a[s]), 32'd32100);
            chk("basic_first_data", 32'(wq_d[s]), 32'h000100);
            chk("basic_last_addr", 32'(wq_a[s + 255]), 32'd41715);
            chk("basic_last_data", 32'(wq_d[s + 255]), 32'h0001FF);
        end
        chk("basic_done", 32'(n_done - d), 32'd1);

        // Transparency
        s = wq_a.size(); s2 = n_wr2;
        draw(8'd2, 10'd10, 10'd10);
        chk("checker_count", 32'(wq_a.size() - s), 32'd128);
        a = 0;
        for (int i = s; i < wq_d.size(); i++) if (wq_d[i] != 24'h123456) a++;
        chk("checker_data", 32'(a), 32'd0);
        chk("nokey_count", 32'(n_wr2 - s2), 32'd256);

        // Clipping
        s = wq_a.size();
        draw(8'd1, 10'd630, 10'd470);
        chk("clip_count", 32'(wq_a.size() - s), 32'd100);
        mx = 0;
        for (int i = s; i < wq_a.size(); i++) if (int'(wq_a[i]) > mx) mx = int'(wq_a[i]);
        chk("clip_max_addr", 32'(mx), 32'd307199);
        s = wq_a.size(); d = n_done;
        draw(8'd1, 10'd700, 10'd0);
        chk("offscreen_count", 32'(wq_a.size() - s), 32'd0);
        chk("offscreen_done", 32'(n_done - d), 32'd1);

        // Handshake: valid held high with changing fields
        a = acc_q.size();
        @(posedge clk); #1;
        req_valid = 1'b1;
        repeat (540) begin
            req_glyph = 8'($urandom); req_x = 10'($urandom); req_y = 10'($urandom);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("hs_accepts", 32'(acc_q.size() - a), 32'd3);
        if (acc_q.size() - a >= 3) begin
            chk("hs_gap1", 32'(acc_q[a + 1] - acc_q[a]), 32'd259);
            chk("hs_gap2", 32'(acc_q[a + 2] - acc_q[a + 1]), 32'd259);
        end
        wait_n = 0;
        while (!req_ready && wait_n < 600) begin @(negedge clk); wait_n++; end
        chk("hs_drain", 32'(req_ready), 32'd1);

        // Reset mid-draw
        @(posedge clk); #1;
        req_valid = 1'b1; req_glyph = 8'd1; req_x = 10'd100; req_y = 10'd50;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        s = wq_a.size(); d = n_done;
        repeat (300) @(negedge clk);
        chk("abort_writes", 32'(wq_a.size() - s), 32'd0);
        chk("abort_done", 32'(n_done - d), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        s = wq_a.size();
        draw(8'd1, 10'd100, 10'd50);
        chk("after_abort_count", 32'(wq_a.size() - s), 32'd256);

        // Random draws
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            d = n_done;
            draw(8'($urandom_range(3, 255)), 10'($urandom_range(0, 699)),
                 10'($urandom_range(0, 499)));
            chk("rand_done", 32'(n_done - d), 32'd1);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
